// File: rtl/capture_input_conditioner.sv
// Capture-timer front end: per path synchroniser -> stability filter -> rising-edge pulse.
// Three independent paths (start, capture, rst_capture) per channel.
module cic_path #(
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_LEN      = 4,
  parameter int FILTER_BITWIDTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  input  logic en_i,
  output logic level_o,
  output logic pulse_o
);
  localparam logic [FILTER_BITWIDTH-1:0] LAST = FILTER_BITWIDTH'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0]     sync_q;
  logic                       f_q, f_d, pulse_q, pulse_d;
  logic [FILTER_BITWIDTH-1:0] cnt_q, cnt_d;
  logic                       s_w, accept_w;

  assign s_w      = sync_q[SYNC_STAGES-1];
  assign accept_w = (s_w != f_q) && (cnt_q == LAST);

  always_comb begin
    f_d     = f_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (s_w == f_q) begin
      cnt_d = '0;
    end else if (accept_w) begin
      f_d     = s_w;
      cnt_d   = '0;
      // Only a 0->1 acceptance pulses; disabled channels drop the edge for good.
      pulse_d = s_w & en_i;
    end else begin
      cnt_d = cnt_q + FILTER_BITWIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      f_q     <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = f_q;
  assign pulse_o = pulse_q;
endmodule

module capture_input_conditioner #(
  parameter int NB_CAPTURES     = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_LEN      = 4,
  parameter int FILTER_BITWIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NB_CAPTURES-1:0]   start_in_i,
  input  logic [NB_CAPTURES-1:0]   capture_in_i,
  input  logic [NB_CAPTURES-1:0]   rst_capture_in_i,
  input  logic [NB_CAPTURES-1:0]   enable_i,
  output logic [NB_CAPTURES-1:0]   start_in_rising_o,
  output logic [NB_CAPTURES-1:0]   capture_in_rising_o,
  output logic [NB_CAPTURES-1:0]   rst_capture_in_rising_o,
  output logic [3*NB_CAPTURES-1:0] filtered_o
);
  // [ch][0]=start, [1]=capture, [2]=rst_capture; flattening gives bit 3*ch+k.
  logic [NB_CAPTURES-1:0][2:0] raw_w, lvl_w, pls_w;

  for (genvar ch = 0; ch < NB_CAPTURES; ch++) begin : g_ch
    assign raw_w[ch] = {rst_capture_in_i[ch], capture_in_i[ch], start_in_i[ch]};
    assign start_in_rising_o[ch]       = pls_w[ch][0];
    assign capture_in_rising_o[ch]     = pls_w[ch][1];
    assign rst_capture_in_rising_o[ch] = pls_w[ch][2];
    for (genvar k = 0; k < 3; k++) begin : g_path
      cic_path #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .FILTER_BITWIDTH(FILTER_BITWIDTH)
      ) u_path (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (raw_w[ch][k]),
        .en_i   (enable_i[ch]),
        .level_o(lvl_w[ch][k]),
        .pulse_o(pls_w[ch][k])
      );
    end
  end

  assign filtered_o = lvl_w;
endmodule

// File: tb/tb_capture_input_conditioner.sv
// Bench for capture_input_conditioner: directed scenarios plus random traffic,
// checked every cycle against a sample-window model of the filter.
module tb_capture_input_conditioner;
  localparam int NB = 10, SS = 2, FL = 4, FBW = 8;
  localparam int NP = 3 * NB, D = SS + FL;

  logic          clk = 1'b0, rst;
  logic [NB-1:0] st, cp, rc, en;
  logic [NB-1:0] st_r, cp_r, rc_r;
  logic [NP-1:0] filt;

  int checks = 0, failures = 0;
  int n;

  // Model: samp[p][k] = input seen k edges ago; a level change is accepted once
  // the FL synchronised samples all disagree with the current filtered level.
  bit samp[NP][D];
  bit mf[NP];
  bit mp[NP];

  capture_input_conditioner #(
    .NB_CAPTURES(NB), .SYNC_STAGES(SS), .FILTER_LEN(FL), .FILTER_BITWIDTH(FBW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .start_in_i(st), .capture_in_i(cp), .rst_capture_in_i(rc), .enable_i(en),
    .start_in_rising_o(st_r), .capture_in_rising_o(cp_r),
    .rst_capture_in_rising_o(rc_r), .filtered_o(filt)
  );

  always #5 clk = ~clk;

  function automatic bit raw_bit(int p);
    case (p % 3)
      0:       return st[p/3];
      1:       return cp[p/3];
      default: return rc[p/3];
    endcase
  endfunction

  task automatic model_update();
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        for (int k = 0; k < D; k++) samp[p][k] = 1'b0;
        mf[p] = 1'b0;
        mp[p] = 1'b0;
      end else begin
        bit flip;
        for (int k = D - 1; k > 0; k--) samp[p][k] = samp[p][k-1];
        samp[p][0] = raw_bit(p);
        flip = 1'b1;
        for (int k = SS; k < SS + FL; k++) if (samp[p][k] == mf[p]) flip = 1'b0;
        mp[p] = 1'b0;
        if (flip) begin
          mf[p] = ~mf[p];
          mp[p] = mf[p] & en[p/3];
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_model(string tag);
    logic [NB-1:0] es, ec, er;
    logic [NP-1:0] ef;
    for (int ch = 0; ch < NB; ch++) begin
      es[ch] = mp[3*ch];
      ec[ch] = mp[3*ch+1];
      er[ch] = mp[3*ch+2];
    end
    for (int p = 0; p < NP; p++) ef[p] = mf[p];
    chk({tag, ".start"}, 64'(st_r), 64'(es));
    chk({tag, ".cap"},   64'(cp_r), 64'(ec));
    chk({tag, ".rstc"},  64'(rc_r), 64'(er));
    chk({tag, ".filt"},  64'(filt), 64'(ef));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_update();
    #1;
    check_model(tag);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_update();
    check_model("async_rst");
  endtask

  task automatic settle(int cyc);
    for (int i = 0; i < cyc; i++) tick("settle");
  endtask

  initial begin
    rst = 1'b0;
    st = '1; cp = '1; rc = '1; en = '1;
    #1;
    rst = 1'b1;
    model_update();

    // Reset held with all inputs high: everything stays 0.
    for (int i = 0; i < 3; i++) tick("in_reset");
    chk("reset_filt_zero", 64'(filt), 64'(0));

    // Release with inputs high: every path pulses once after edge SS+FL.
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick("post_rst");
      chk("post_rst_quiet", 64'({st_r, cp_r, rc_r}), 64'(0));
    end
    tick("post_rst");
    chk("post_rst_all_pulse", 64'({st_r, cp_r, rc_r}), {34'd0, {30{1'b1}}});
    tick("post_rst");
    chk("post_rst_one_cycle", 64'({st_r, cp_r, rc_r}), 64'(0));
    settle(10);
    st = '0; cp = '0; rc = '0;
    settle(8);

    // Single channel latency on start[3].
    st[3] = 1'b1;
    for (int i = 1; i <= 5; i++) tick("lat");
    chk("lat_quiet_e5", 64'(st_r), 64'(0));
    tick("lat");
    chk("lat_pulse_e6", 64'({st_r, cp_r, rc_r}), 64'(1 << 23));
    chk("lat_filt9", 64'(filt[9]), 64'(1));
    tick("lat");
    chk("lat_one_cycle", 64'(st_r), 64'(0));
    settle(13);
    st[3] = 1'b0;
    settle(8);

    // Glitch rejection on capture[0]: 3 high, 1 low, 3 high, 1 low, then 6 high.
    n = 0;
    for (int i = 0; i < 14; i++) begin
      cp[0] = !(i == 3 || i == 7);
      tick("glitch");
      n += int'(cp_r[0]);
      if (i == 7) chk("glitch_none_yet", 64'(n), 64'(0));
    end
    cp[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick("glitch");
      n += int'(cp_r[0]);
    end
    chk("glitch_one_pulse", 64'(n), 64'(1));

    // Enable gating on rst_capture[5].
    en[5] = 1'b0;
    rc[5] = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick("en_off");
      n += int'(rc_r[5]);
    end
    chk("en_off_filt17", 64'(filt[17]), 64'(1));
    en[5] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("en_on");
      n += int'(rc_r[5]);
    end
    chk("en_no_replay", 64'(n), 64'(0));
    rc[5] = 1'b0;
    for (int i = 0; i < 4; i++) tick("en_drop");
    rc[5] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick("en_rearm");
      n += int'(rc_r[5]);
    end
    chk("en_rearm_pulse", 64'(n), 64'(1));
    rc[5] = 1'b0;
    settle(8);

    // Simultaneous start/capture/rst_capture on channel 2.
    st[2] = 1'b1; cp[2] = 1'b1; rc[2] = 1'b1;
    for (int i = 0; i < 6; i++) tick("simul");
    chk("simul_all3", 64'({st_r, cp_r, rc_r}), 64'((1 << 22) | (1 << 12) | (1 << 2)));
    tick("simul");
    st = '0; cp = '0; rc = '0;
    settle(8);

    // Mid-filter reset: partial count discarded, full latency after release.
    st[7] = 1'b1;
    tick("mid");
    tick("mid");
    async_reset();
    tick("mid_rst");
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick("mid_rel");
      n += int'(st_r[7]);
    end
    chk("mid_no_early", 64'(n), 64'(0));
    tick("mid_rel");
    chk("mid_pulse", 64'(st_r), 64'(1 << 7));
    st[7] = 1'b0;
    settle(8);

    // Random traffic: slow-toggling inputs, occasional enable changes and resets.
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(5) == 0) st[b] = ~st[b];
        if ($urandom_range(5) == 0) cp[b] = ~cp[b];
        if ($urandom_range(5) == 0) rc[b] = ~rc[b];
        if ($urandom_range(9) == 0) en[b] = ~en[b];
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(149) == 0) async_reset();
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/capture_input_conditioner.md
# capture_input_conditioner

Front-end conditioning stage for the capture timer channels. It takes raw, asynchronous start / capture / reset-capture inputs for every channel, then synchronises, glitch-filters and edge-detects them. It delivers single-cycle rising-edge pulses directly to the `start_in_rising_i`, `capture_in_rising_i` and `rst_capture_in_rising_i` inputs of the capture FSM stage. Each of the 3×NB_CAPTURES signal paths is independent and identical.

## Interface

**Parameters**
- `NB_CAPTURES`, 10: number of capture channels.
- `SYNC_STAGES`, 2: synchroniser depth. Legal range 2..4.
- `FILTER_LEN`, 4: consecutive stable cycles required to accept a level change. Legal range 1..255.
- `FILTER_BITWIDTH`, 8: filter counter width. Must be able to hold FILTER_LEN.

**Ports**
- `clk_i`, input, 1: single clock; all logic is rising-edge.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `start_in_i`, input, NB_CAPTURES: raw asynchronous start inputs, one bit per channel.
- `capture_in_i`, input, NB_CAPTURES: raw asynchronous capture inputs.
- `rst_capture_in_i`, input, NB_CAPTURES: raw asynchronous capture-register clear inputs.
- `enable_i`, input, NB_CAPTURES: per-channel pulse enable, synchronous to clk_i.
- `start_in_rising_o`, output, NB_CAPTURES: one-cycle pulse on an accepted start rising edge.
- `capture_in_rising_o`, output, NB_CAPTURES: one-cycle pulse on an accepted capture rising edge.
- `rst_capture_in_rising_o`, output, NB_CAPTURES: one-cycle pulse on an accepted reset-capture rising edge.
- `filtered_o`, output, 3*NB_CAPTURES: filtered levels. Bit [3i] is start, [3i+1] is capture, [3i+2] is rst_capture for channel i.

## Operation

Each path runs through the same chain: synchroniser → filter → edge detector. All registers are per path.

**Synchroniser**
- SYNC_STAGES flops in series.
- The last stage output is `s`.

**Filter**
- State per path: level register `f` (reset 0) and counter `cnt` (reset 0).
- If `s == f`: `cnt <= 0`.
- Else if `cnt + 1 == FILTER_LEN`: `f <= s` and `cnt <= 0`.
- Else: `cnt <= cnt + 1`.
- A deviation shorter than FILTER_LEN consecutive cycles is discarded. The counter restarts from 0 whenever `s` returns to `f`.
- The counter never wraps. It is bounded by FILTER_LEN-1.

**Edge detector**
- A pulse output is registered 1 on the same edge at which `f` updates 0→1, and only if `enable_i[ch]` is 1 at that edge.
- Otherwise the pulse output is 0.
- Falling updates (1→0) never pulse.

**Enable**
- `enable_i` low suppresses pulses only. The synchroniser and filter keep tracking.
- A rising edge accepted while the channel is disabled is lost. It is not replayed when enable later rises.

**Simultaneous events**
- Paths are independent. Start, capture and rst_capture pulses on the same channel, in the same cycle, are all emitted.
- Priority between them belongs to the downstream FSM stage.

**Reset**
- `rst_i` high asynchronously clears all synchroniser flops, `f`, `cnt` and every output to 0.
- Reset asserted mid-filter discards the partial count.
- If an input is already high when reset releases, it is treated as a rising edge. One pulse is emitted after the full latency.

## Timing

**Reset values**
- All outputs are 0.

**Latency**
- An input that is high and stable with setup before edge 1 produces a pulse visible after edge SYNC_STAGES+FILTER_LEN.
- With the defaults, that is after edge 6; the pulse is high for exactly one cycle, until edge 7.
- With FILTER_LEN=1, latency is SYNC_STAGES+1 edges.
- `filtered_o` rises on the same edge as the pulse.

**Minimum widths**
- Minimum accepted input high width: FILTER_LEN cycles, as seen at `s`.
- Minimum low gap between two accepted pulses: FILTER_LEN cycles low, then FILTER_LEN cycles high.
- At most one pulse per FILTER_LEN cycles per path.

**Register boundaries**
- Outputs are registered.
- No combinational path exists from any input to any output.

## Test plan

- **Reset state:** hold `rst_i`=1 with all inputs 1 → all outputs 0. Release with all inputs still high and enable all 1 → every pulse output fires once, after edge 6 with defaults, and never again while the inputs stay high.
- **Single channel latency:** `start_in_i[3]` 0→1 held for 20 cycles, defaults → `start_in_rising_o[3]`=1 for exactly one cycle, 6 edges after the input change. All other bits stay 0. `filtered_o[9]` goes 1 on the same edge.
- **Glitch rejection:** `capture_in_i[0]` high for 3 cycles, low for 1, high for 3, FILTER_LEN=4 → no pulse. Then high for 4 cycles → one pulse.
- **Enable gating:** `enable_i[5]`=0 while `rst_capture_in_i[5]` rises and is held → no pulse, but `filtered_o[17]`=1. Raise enable → still no pulse. Drop the input for 4 cycles, raise it again → one pulse.
- **Simultaneous events:** start, capture and rst_capture on channel 2 rise in the same cycle → all three pulse outputs are high in the same single cycle.
- **Mid-filter reset:** input rises, `rst_i` pulses 2 cycles later, input stays high → the pulse appears SYNC_STAGES+FILTER_LEN edges after reset release, not before.
